// File: rtl/fb_burst_writer.sv
// -----------------------------------------------------------------------------
// fb_burst_writer
//
// Purpose:
//   Takes the RGB pixel stream from the framebuffer source multiplexer, packs
//   two 32-bit pixels ({8'h00, r, g, b}) into each 64-bit word, queues the
//   words in an internal FIFO and writes whole frames to DDR through an
//   Avalon-MM burst write master. Frame completion and FIFO overflow are
//   reported to the HPS/readout side.
//
// Optional feature (compile-time macro FB_PINGPONG_EN):
//   defined   : wr_buf_idx toggles at every frame end, so frames alternate
//               between fb_base_addr and fb_base_addr + FRAME_BYTES.
//   undefined : wr_buf_idx stays 0 and every frame starts at fb_base_addr.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   r_fb/g_fb/b_fb         pixel colour components
//   data_fb_valid          pixel qualifier (no backpressure upstream)
//   sop_fb/eop_fb          first/last pixel of frame, valid with data_fb_valid
//   fb_base_addr           DDR byte address of buffer 0
//   overflow_clr           clears the sticky overflow flag
//   avm_*                  Avalon-MM burst write master
//   frame_done             one-cycle pulse after the last word of a frame
//   wr_buf_idx             buffer currently being written
//   overflow               sticky: a word was dropped on a full FIFO
//
// Handshake: a beat transfers on a cycle where avm_write=1 and
// avm_waitrequest=0. While waitrequest is high, avm_write, avm_address and
// avm_burstcount are held; writedata/byteenable follow the FIFO head, which
// only advances on a transferred beat.
// -----------------------------------------------------------------------------
module fb_burst_writer #(
  parameter int          FIFO_AW     = 8,
  parameter int          BURST_LEN   = 16,
  parameter logic [31:0] FRAME_BYTES = 32'h0012_C000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  r_fb,
  input  logic [7:0]  g_fb,
  input  logic [7:0]  b_fb,
  input  logic        data_fb_valid,
  input  logic        sop_fb,
  input  logic        eop_fb,
  input  logic [31:0] fb_base_addr,
  input  logic        overflow_clr,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [63:0] avm_writedata,
  output logic [7:0]  avm_byteenable,
  output logic [7:0]  avm_burstcount,
  input  logic        avm_waitrequest,
  output logic        frame_done,
  output logic        wr_buf_idx,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  // ---------------------------------------------------------------------------
  // Packer
  // ---------------------------------------------------------------------------
  logic        phase_q, phase_d;        // 0: next pixel is even
  logic [31:0] lo_q, lo_d;              // held even pixel
  logic        sop_pend_q, sop_pend_d;  // next pushed word is the frame's first

  logic [31:0] pix;
  logic        push;
  logic [63:0] push_data;
  logic        push_half;
  logic        push_sop;
  logic        push_eop;

  assign pix = {8'h00, r_fb, g_fb, b_fb};

  always_comb begin
    phase_d    = phase_q;
    lo_d       = lo_q;
    sop_pend_d = sop_pend_q;
    push       = 1'b0;
    push_data  = 64'd0;
    push_half  = 1'b0;
    push_sop   = 1'b0;
    push_eop   = 1'b0;
    if (data_fb_valid) begin
      // sop forces an even pixel, discarding any unfinished half-word.
      if (sop_fb || !phase_q) begin
        lo_d    = pix;
        phase_d = 1'b1;
        if (sop_fb) sop_pend_d = 1'b1;
        if (eop_fb) begin
          push       = 1'b1;
          push_data  = {32'd0, pix};
          push_half  = 1'b1;
          push_sop   = sop_fb | sop_pend_q;
          push_eop   = 1'b1;
          phase_d    = 1'b0;
          sop_pend_d = 1'b0;
        end
      end else begin
        push       = 1'b1;
        push_data  = {pix, lo_q};
        push_sop   = sop_pend_q;
        push_eop   = eop_fb;
        phase_d    = 1'b0;
        sop_pend_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO: data/half in a memory, sop/eop flags in flat vectors so the burst
  // window can be scanned without a memory read port per entry.
  // ---------------------------------------------------------------------------
  logic [64:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]   sop_bits_q;
  logic [DEPTH-1:0]   eop_bits_q;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      eop_pending_q, eop_pending_d;

  logic        full;
  logic        do_push;
  logic        drop;
  logic        beat;
  logic [64:0] head_word;
  logic        head_sop;
  logic        head_eop;

  assign full      = (count_q == CW'(DEPTH));
  assign do_push   = push && !full;
  assign drop      = push && full;
  assign head_word = mem_q[rd_ptr_q];
  assign head_sop  = sop_bits_q[rd_ptr_q];
  assign head_eop  = eop_bits_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q]      <= {push_half, push_data};
      sop_bits_q[wr_ptr_q] <= push_sop;
      eop_bits_q[wr_ptr_q] <= push_eop;
    end
  end

  always_comb begin
    count_d = count_q;
    if (do_push && !beat)      count_d = count_q + CW'(1);
    else if (!do_push && beat) count_d = count_q - CW'(1);

    eop_pending_d = eop_pending_q;
    if ((do_push && push_eop) && !(beat && head_eop))
      eop_pending_d = eop_pending_q + CW'(1);
    else if (!(do_push && push_eop) && (beat && head_eop))
      eop_pending_d = eop_pending_q - CW'(1);
  end

  // A full burst is allowed only if it ends no later than an eop word and
  // does not carry the next frame's sop word past its first beat.
  logic               win_break;
  logic [FIFO_AW-1:0] win_idx;

  always_comb begin
    win_break = 1'b0;
    win_idx   = rd_ptr_q;
    for (int i = 0; i < BURST_LEN; i++) begin
      win_idx = rd_ptr_q + FIFO_AW'(i);
      if ((i < BURST_LEN - 1) && eop_bits_q[win_idx]) win_break = 1'b1;
      if ((i > 0) && sop_bits_q[win_idx])             win_break = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic        avm_write_q, avm_write_d;
  logic [31:0] avm_address_q, avm_address_d;
  logic [7:0]  avm_burstcount_q, avm_burstcount_d;
  logic [7:0]  beats_left_q, beats_left_d;
  logic [31:0] frame_addr_q, frame_addr_d;
  logic        frame_done_q, frame_done_d;
  logic        buf_idx_q, buf_idx_d;
  logic        overflow_q, overflow_d;

  logic [31:0] start_addr;
  logic        start;
  logic [7:0]  start_len;

  assign beat = (state_q == S_BURST) && avm_write_q && !avm_waitrequest;

  // Relatch the frame base only when the sop word reaches the head, so words
  // of a still-draining frame keep their addresses.
  assign start_addr = head_sop ? (fb_base_addr + (buf_idx_q ? FRAME_BYTES : 32'd0))
                               : frame_addr_q;

  always_comb begin
    state_d          = state_q;
    avm_write_d      = avm_write_q;
    avm_address_d    = avm_address_q;
    avm_burstcount_d = avm_burstcount_q;
    beats_left_d     = beats_left_q;
    frame_addr_d     = frame_addr_q;
    frame_done_d     = 1'b0;
    buf_idx_d        = buf_idx_q;
    start            = 1'b0;
    start_len        = 8'd0;

    overflow_d = overflow_q;
    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((count_q >= CW'(BURST_LEN)) && !win_break) begin
          start     = 1'b1;
          start_len = 8'(BURST_LEN);
        end else if ((eop_pending_q != '0) || (count_q >= CW'(BURST_LEN))) begin
          // Frame tail, or a window broken by a frame boundary: drain singly.
          start     = 1'b1;
          start_len = 8'd1;
        end
        if (start) begin
          state_d          = S_BURST;
          avm_write_d      = 1'b1;
          avm_address_d    = start_addr;
          avm_burstcount_d = start_len;
          beats_left_d     = start_len;
          frame_addr_d     = start_addr;
        end
      end
      S_BURST: begin
        if (beat) begin
          beats_left_d = beats_left_q - 8'd1;
          if (head_eop) begin
            frame_done_d = 1'b1;
`ifdef FB_PINGPONG_EN
            buf_idx_d = ~buf_idx_q;
`endif
          end
          if (beats_left_q == 8'd1) begin
            state_d      = S_IDLE;
            avm_write_d  = 1'b0;
            frame_addr_d = frame_addr_q + {21'd0, avm_burstcount_q, 3'd0};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q          <= 1'b0;
      lo_q             <= 32'd0;
      sop_pend_q       <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      eop_pending_q    <= '0;
      state_q          <= S_IDLE;
      avm_write_q      <= 1'b0;
      avm_address_q    <= 32'd0;
      avm_burstcount_q <= 8'd0;
      beats_left_q     <= 8'd0;
      frame_addr_q     <= 32'd0;
      frame_done_q     <= 1'b0;
      buf_idx_q        <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      phase_q          <= phase_d;
      lo_q             <= lo_d;
      sop_pend_q       <= sop_pend_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (beat)    rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q          <= count_d;
      eop_pending_q    <= eop_pending_d;
      state_q          <= state_d;
      avm_write_q      <= avm_write_d;
      avm_address_q    <= avm_address_d;
      avm_burstcount_q <= avm_burstcount_d;
      beats_left_q     <= beats_left_d;
      frame_addr_q     <= frame_addr_d;
      frame_done_q     <= frame_done_d;
      buf_idx_q        <= buf_idx_d;
      overflow_q       <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Data lanes are gated so the bus is quiet outside a burst.
  // ---------------------------------------------------------------------------
  assign avm_write      = avm_write_q;
  assign avm_address    = avm_address_q;
  assign avm_burstcount = avm_burstcount_q;
  assign avm_writedata  = avm_write_q ? head_word[63:0] : 64'd0;
  assign avm_byteenable = avm_write_q ? (head_word[64] ? 8'h0F : 8'hFF) : 8'h00;
  assign frame_done     = frame_done_q;
  assign wr_buf_idx     = buf_idx_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_fb_burst_writer.sv
// -----------------------------------------------------------------------------
// tb_fb_burst_writer
//
// Directed frames are driven into fb_burst_writer. Each frame's expected DDR
// beats (address, data, byteenable, burstcount) are pushed into exp_q when
// the frame is issued; an independent monitor on the falling edge pops one
// entry per accepted Avalon beat and compares it.
// -----------------------------------------------------------------------------
module tb_fb_burst_writer;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] FB   = 32'h0012_C000;
`ifdef FB_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [7:0]  r_fb, g_fb, b_fb;
  logic        data_fb_valid, sop_fb, eop_fb;
  logic [31:0] fb_base_addr;
  logic        overflow_clr;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [63:0] avm_writedata;
  logic [7:0]  avm_byteenable;
  logic [7:0]  avm_burstcount;
  logic        avm_waitrequest;
  logic        frame_done;
  logic        wr_buf_idx;
  logic        overflow;

  fb_burst_writer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .r_fb            (r_fb),
    .g_fb            (g_fb),
    .b_fb            (b_fb),
    .data_fb_valid   (data_fb_valid),
    .sop_fb          (sop_fb),
    .eop_fb          (eop_fb),
    .fb_base_addr    (fb_base_addr),
    .overflow_clr    (overflow_clr),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_burstcount  (avm_burstcount),
    .avm_waitrequest (avm_waitrequest),
    .frame_done      (frame_done),
    .wr_buf_idx      (wr_buf_idx),
    .overflow        (overflow)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard state: {burstcount[7:0], byteenable[7:0], addr[31:0], data[63:0]}
  // ---------------------------------------------------------------------------
  logic [111:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           done_cnt = 0;
  bit           wr_mode  = 1'b0;  // 1: waitrequest toggles every cycle
  logic         exp_idx  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pix(input logic [7:0] tag, input int n);
    logic [15:0] nn;
    nn = n[15:0];
    return {8'h00, nn[7:0], tag, 6'd0, nn[9:8]};
  endfunction

  function automatic logic [31:0] buf_base();
    return BASE + (exp_idx ? FB : 32'd0);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_mode) avm_waitrequest = ~avm_waitrequest;
  endtask

  task automatic send_frame(input int n_pix, input logic [7:0] tag,
                            input logic [31:0] base, input logic [7:0] bc,
                            input int max_words, input bit push_exp);
    int          words;
    logic [31:0] lo, hi, p;
    logic [7:0]  be;
    words = (n_pix + 1) / 2;
    if (push_exp) begin
      for (int k = 0; k < words && k < max_words; k++) begin
        lo = pix(tag, 2 * k);
        if (2 * k + 1 < n_pix) begin
          hi = pix(tag, 2 * k + 1);
          be = 8'hFF;
        end else begin
          hi = 32'd0;
          be = 8'h0F;
        end
        exp_q.push_back({bc, be, base + 32'(8 * k), hi, lo});
      end
    end
    for (int n = 0; n < n_pix; n++) begin
      tick();
      p             = pix(tag, n);
      r_fb          = p[23:16];
      g_fb          = p[15:8];
      b_fb          = p[7:0];
      data_fb_valid = 1'b1;
      sop_fb        = (n == 0);
      eop_fb        = (n == n_pix - 1);
    end
    tick();
    data_fb_valid = 1'b0;
    sop_fb        = 1'b0;
    eop_fb        = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    repeat (6) tick();
  endtask

  task automatic frame_ended();
    if (PP) exp_idx = ~exp_idx;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: one expected entry per accepted beat; burst fields held stable
  // ---------------------------------------------------------------------------
  bit           in_burst = 1'b0;
  logic [31:0]  bst_addr;
  logic [7:0]   bst_cnt;
  int           beat_idx = 0;
  logic [111:0] e;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_burst = 1'b0;
      beat_idx = 0;
    end else begin
      if (frame_done) done_cnt++;
      if (avm_write) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          bst_addr = avm_address;
          bst_cnt  = avm_burstcount;
          beat_idx = 0;
        end else begin
          chk("burst_addr_stable", avm_address, bst_addr);
          chk("burstcount_stable", avm_burstcount, bst_cnt);
        end
        if (!avm_waitrequest) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat: got addr %h data %h, expected no beat",
                     avm_address, avm_writedata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_addr", bst_addr + 32'(8 * beat_idx), e[95:64]);
            chk("beat_data", avm_writedata, e[63:0]);
            chk("beat_be", avm_byteenable, e[103:96]);
            chk("beat_burstcount", avm_burstcount, e[111:104]);
          end
          beat_idx++;
          if (beat_idx >= int'(bst_cnt)) in_burst = 1'b0;
        end
      end else if (in_burst) begin
        n_checks++;
        n_errors++;
        $display("FAIL write_dropped_mid_burst: got avm_write 0 after %0d of %0d beats, expected 1",
                 beat_idx, bst_cnt);
        in_burst = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int d0;
  int wr_high;

  initial begin
    reset_n         = 1'b0;
    r_fb            = 8'd0;
    g_fb            = 8'd0;
    b_fb            = 8'd0;
    data_fb_valid   = 1'b0;
    sop_fb          = 1'b0;
    eop_fb          = 1'b0;
    fb_base_addr    = BASE;
    overflow_clr    = 1'b0;
    avm_waitrequest = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_avm_write", avm_write, 1'b0);
    chk("rst_avm_address", avm_address, 32'd0);
    chk("rst_avm_burstcount", avm_burstcount, 8'd0);
    chk("rst_avm_writedata", avm_writedata, 64'd0);
    chk("rst_avm_byteenable", avm_byteenable, 8'd0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_wr_buf_idx", wr_buf_idx, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    reset_n = 1'b1;
    repeat (2) tick();

    // 32-pixel frame: one burst of 16 at buffer 0
    d0 = done_cnt;
    send_frame(32, 8'h11, buf_base(), 8'd16, 1000, 1'b1);
    wait_drain("t1_drain", 500);
    chk("t1_frame_done", 64'(done_cnt - d0), 64'd1);
    frame_ended();
    chk("t1_wr_buf_idx", wr_buf_idx, exp_idx);

    // Second 32-pixel frame: pong buffer when double buffering is enabled
    d0 = done_cnt;
    send_frame(32, 8'h22, buf_base(), 8'd16, 1000, 1'b1);
    wait_drain("t2_drain", 500);
    chk("t2_frame_done", 64'(done_cnt - d0), 64'd1);
    frame_ended();
    chk("t2_wr_buf_idx", wr_buf_idx, exp_idx);

    // 3-pixel frame: full word then half word, both single-beat
    d0 = done_cnt;
    send_frame(3, 8'h33, buf_base(), 8'd1, 1000, 1'b1);
    wait_drain("t3_drain", 200);
    chk("t3_frame_done", 64'(done_cnt - d0), 64'd1);
    frame_ended();
    chk("t3_wr_buf_idx", wr_buf_idx, exp_idx);

    // waitrequest toggling during the burst
    d0 = done_cnt;
    wr_mode = 1'b1;
    send_frame(32, 8'h44, buf_base(), 8'd16, 1000, 1'b1);
    wait_drain("t4_drain", 500);
    wr_mode = 1'b0;
    avm_waitrequest = 1'b0;
    chk("t4_frame_done", 64'(done_cnt - d0), 64'd1);
    frame_ended();
    chk("t4_wr_buf_idx", wr_buf_idx, exp_idx);

    // Overflow: 600 pixels = 300 words into a 256-word FIFO under a stall;
    // the last 44 words (including the eop word) are dropped.
    d0 = done_cnt;
    avm_waitrequest = 1'b1;
    send_frame(600, 8'h55, buf_base(), 8'd16, 256, 1'b1);
    repeat (5) tick();
    chk("t5_overflow_set", overflow, 1'b1);
    chk("t5_stalled_write", avm_write, 1'b1);
    avm_waitrequest = 1'b0;
    wait_drain("t5_drain", 2000);
    repeat (20) tick();
    chk("t5_frame_done", 64'(done_cnt - d0), 64'd0);
    chk("t5_wr_buf_idx", wr_buf_idx, exp_idx);
    chk("t5_overflow_sticky", overflow, 1'b1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("t5_overflow_clr", overflow, 1'b0);

    // Reset in the middle of a stalled burst
    avm_waitrequest = 1'b1;
    send_frame(32, 8'h66, buf_base(), 8'd16, 1000, 1'b0);
    repeat (3) tick();
    chk("t6_stalled_write", avm_write, 1'b1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_reset_write_low", avm_write, 1'b0);
    exp_q.delete();
    avm_waitrequest = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    exp_idx = 1'b0;
    wr_high = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (avm_write) wr_high++;
    end
    chk("t6_fifo_empty_no_write", 64'(wr_high), 64'd0);
    chk("t6_wr_buf_idx_reset", wr_buf_idx, 1'b0);
    d0 = done_cnt;
    send_frame(32, 8'h77, buf_base(), 8'd16, 1000, 1'b1);
    wait_drain("t6_drain", 500);
    chk("t6_frame_done", 64'(done_cnt - d0), 64'd1);
    frame_ended();
    chk("t6_wr_buf_idx", wr_buf_idx, exp_idx);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
